// File: rtl/tilelink_initiator.sv
// ---------------------------------------------------------------------------
// tilelink_initiator
//
// Single-outstanding TileLink-UL initiator. A simple load/store request is
// turned into one A-channel beat. The matching D-channel beat is collected and
// returned to the client as a one-cycle response pulse. Only one transaction
// is in flight at a time.
//
// Optional feature macro: TL_INITIATOR_TIMEOUT_EN
//   Defined   : WAIT_D gives up after TIMEOUT_CYCLES cycles without a matching
//               D beat. It then returns an error response.
//   Undefined : WAIT_D waits indefinitely and TIMEOUT_CYCLES is ignored.
//
// Parameters
//   SOURCE_ID       8-bit source tag. It is driven on a_source and must match
//                   d_source.
//   TIMEOUT_CYCLES  D-wait limit (1..255). Used only with the timeout feature.
//
// Ports
//   clock, reset           single clock; synchronous active-high reset
//   req_valid/req_ready    client request handshake
//   req_write              1 = store, 0 = load
//   req_addr/wdata/mask    request address, store data, store byte enables
//   rsp_valid              one-cycle response pulse
//   rsp_rdata/rsp_error    response payload, held until the next response
//   a_valid/a_ready        A-channel handshake
//   a_opcode/size/source/address/mask/data   A-channel beat fields
//   d_valid/d_ready        D-channel handshake
//   d_opcode/source/data/error               D-channel beat fields
// ---------------------------------------------------------------------------
module tilelink_initiator #(
    parameter logic [7:0]  SOURCE_ID      = 8'd0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,

    output logic        a_valid,
    input  logic        a_ready,
    output logic [2:0]  a_opcode,
    output logic [2:0]  a_size,
    output logic [7:0]  a_source,
    output logic [31:0] a_address,
    output logic [3:0]  a_mask,
    output logic [31:0] a_data,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_opcode,
    input  logic [7:0]  d_source,
    input  logic [31:0] d_data,
    input  logic        d_error
);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] D_ACK          = 3'd0;
    localparam logic [2:0] D_ACK_DATA     = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_WAIT_D
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_a_valid;
    logic        r_d_ready;
    logic        r_rsp_valid;
    logic        r_rsp_error;
    logic [31:0] r_rsp_rdata;
    logic [2:0]  r_a_opcode;
    logic [3:0]  r_a_mask;
    logic [31:0] r_a_address;
    logic [31:0] r_a_data;

    logic        w_req_fire;
    logic        w_a_fire;
    logic        w_d_match;
    logic        w_is_get;
    logic        w_op_error;
    logic        w_timeout;

    assign w_req_fire = (r_state == ST_IDLE) && req_valid && r_req_ready;
    assign w_a_fire   = (r_state == ST_SEND_A) && r_a_valid && a_ready;

    // D beats are only consumed in WAIT_D and only with our own source tag.
    // Everything else is swallowed by d_ready and has no effect.
    assign w_d_match  = (r_state == ST_WAIT_D) && d_valid && r_d_ready &&
                        (d_source == SOURCE_ID);

    assign w_is_get   = (r_a_opcode == OP_GET);

    // A Get must be answered with AccessAckData. A Put must be answered with AccessAck.
    assign w_op_error = w_is_get ? (d_opcode != D_ACK_DATA) : (d_opcode != D_ACK);

`ifdef TL_INITIATOR_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    // The counter is zero in the first WAIT_D cycle. It steps once per cycle
    // without a matching beat. The cycle that sees it at TIMEOUT_CYCLES is the
    // last chance for a real beat. Otherwise the timeout response goes out next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_a_fire) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_WAIT_D) && !w_d_match) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT_D) && !w_d_match &&
                       (r_wait_cnt == 8'(TIMEOUT_CYCLES));
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    // NOTE: every register here uses <= so that all state updates see the
    // values from before the edge. A blocking = would let later lines see
    // half-updated state and would break simulation/synthesis equivalence.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_a_valid   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
            r_a_opcode  <= '0;
            r_a_mask    <= '0;
            r_a_address <= '0;
            r_a_data    <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_d_ready   <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    // req_ready comes up one cycle after reset and stays up
                    // until a request is taken.
                    r_req_ready <= !w_req_fire;
                    if (w_req_fire) begin
                        r_a_address <= req_addr;
                        r_a_data    <= req_wdata;
                        if (!req_write) begin
                            r_a_opcode <= OP_GET;
                            r_a_mask   <= 4'hF;
                        end else begin
                            r_a_opcode <= (req_mask == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
                            r_a_mask   <= req_mask;
                        end
                        r_a_valid <= 1'b1;
                        r_state   <= ST_SEND_A;
                    end
                end

                ST_SEND_A: begin
                    if (w_a_fire) begin
                        r_a_valid <= 1'b0;
                        r_state   <= ST_WAIT_D;
                    end
                end

                ST_WAIT_D: begin
                    if (w_d_match) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_is_get ? d_data : 32'd0;
                        r_rsp_error <= d_error | w_op_error;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_error <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign a_valid   = r_a_valid;
    assign a_opcode  = r_a_opcode;
    assign a_size    = 3'd2;
    assign a_source  = SOURCE_ID;
    assign a_address = r_a_address;
    assign a_mask    = r_a_mask;
    assign a_data    = r_a_data;
    assign d_ready   = r_d_ready;

endmodule
